// File: rtl/enc_pkg.sv
// Shared constants for the 16-to-4 request encoder: line count, code width, FSM states.
package enc_pkg;
  localparam int ENC_N = 16;
  localparam int ENC_W = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;
endpackage

// File: rtl/prio_find.sv
// Combinational index finder: highest set bit, or first set bit after start (wrapping) in round-robin mode.
module prio_find #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  input  logic         rr_en,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] k;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    k     = '0;
    if (rr_en) begin
      // N is a power of two, so the W-bit add wraps naturally back to 0.
      for (int i = 0; i < N; i++) begin
        k = start + W'(i) + W'(1);
        if (!found && mask[k]) begin
          idx   = k;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          idx   = W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/req_encoder_16_to_4.sv
// Sticky 16-line request capture, one 4-bit code per valid/ready transfer; valid one edge after capture,
// 1 code/cycle sustained; y_o/valid_o frozen while ready_i is low, pending bits keep accumulating.
module req_encoder_16_to_4
  import enc_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int W     = ENC_W,
  parameter bit RR_EN = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  input  logic         clr_i,
  input  logic         ready_i,
  output logic [W-1:0] y_o,
  output logic         valid_o,
  output logic [N-1:0] pend_o,
  output logic         ovf_o
);

  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] req_m, served, cand;
  logic [W-1:0] y_q, y_d, last_q, last_d, sel_idx;
  logic         valid_q, valid_d, ovf_q, ovf_d, state_q, state_d;
  logic         sel_found, hs;

  assign hs    = valid_q & ready_i;
  assign req_m = req_i & {N{en_i}};
  assign cand  = pend_q & ~served;

  always_comb begin
    served = '0;
    if (hs) served[y_q] = 1'b1;
  end

  prio_find #(.N(N)) u_find (
    .mask  (cand),
    .start (last_q),
    .rr_en (RR_EN),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    pend_d  = cand | req_m;
    ovf_d   = |(req_m & cand);
    y_d     = y_q;
    valid_d = valid_q;
    state_d = state_q;
    last_d  = last_q;
    if (clr_i) begin
      // Flush wins over capture and over a coincident handshake; y and last are kept.
      pend_d  = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE || hs) begin
      if (sel_found) begin
        y_d     = sel_idx;
        last_d  = sel_idx;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end else begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= ST_IDLE;
      last_q  <= W'(N - 1);
    end else begin
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_req_encoder_16_to_4.sv
// Directed bench: a fixed-priority and a round-robin instance share all inputs.
module tb_req_encoder_16_to_4;

  logic        clk = 1'b0;
  logic        rst, en, clr, ready;
  logic [15:0] req;
  logic [3:0]  f_y, r_y;
  logic        f_valid, f_ovf, r_valid, r_ovf;
  logic [15:0] f_pend, r_pend;
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  req_encoder_16_to_4 #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .clr_i(clr), .ready_i(ready),
    .y_o(f_y), .valid_o(f_valid), .pend_o(f_pend), .ovf_o(f_ovf)
  );

  req_encoder_16_to_4 #(.RR_EN(1'b1)) dut_rr (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .clr_i(clr), .ready_i(ready),
    .y_o(r_y), .valid_o(r_valid), .pend_o(r_pend), .ovf_o(r_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; ready = 1'b0; req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; ready = 1'b0; req = '0;
    #2;
    n_chk++; if (f_y !== 4'h0)     $display("FAIL reset_y got %h want 0", f_y); else n_pass++;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", f_valid); else n_pass++;
    n_chk++; if (f_pend !== 16'h0) $display("FAIL reset_pend got %h want 0000", f_pend); else n_pass++;
    n_chk++; if (f_ovf !== 1'b0)   $display("FAIL reset_ovf got %b want 0", f_ovf); else n_pass++;
    n_chk++; if (r_valid !== 1'b0) $display("FAIL reset_rr_valid got %b want 0", r_valid); else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req = 16'h0030;
    tick();
    req = '0;
    tick();
    n_chk++; if (f_valid !== 1'b1)    $display("FAIL midrst_pre_valid got %b want 1", f_valid); else n_pass++;
    n_chk++; if (f_y !== 4'h5)        $display("FAIL midrst_pre_y got %h want 5", f_y); else n_pass++;
    n_chk++; if (f_pend !== 16'h0030) $display("FAIL midrst_pre_pend got %h want 0030", f_pend); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (f_y !== 4'h0)     $display("FAIL midrst_y got %h want 0", f_y); else n_pass++;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", f_valid); else n_pass++;
    n_chk++; if (f_pend !== 16'h0) $display("FAIL midrst_pend got %h want 0000", f_pend); else n_pass++;
    n_chk++; if (f_ovf !== 1'b0)   $display("FAIL midrst_ovf got %b want 0", f_ovf); else n_pass++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (f_valid !== 1'b0 || f_pend !== 16'h0)
        $display("FAIL midrst_idle[%0d] got valid=%b pend=%h want 0/0000", i, f_valid, f_pend); else n_pass++;
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] exp_y [4];
    exp_y[0] = 4'hF; exp_y[1] = 4'hA; exp_y[2] = 4'h5; exp_y[3] = 4'h0;
    do_reset();
    ready = 1'b1;
    req   = 16'h8421;
    tick();
    req = '0;
    n_chk++; if (f_pend !== 16'h8421) $display("FAIL fp_capture_pend got %h want 8421", f_pend); else n_pass++;
    n_chk++; if (f_valid !== 1'b0)    $display("FAIL fp_capture_valid got %b want 0", f_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (f_valid !== 1'b1 || f_y !== exp_y[i])
        $display("FAIL fp_seq[%0d] got valid=%b y=%h want 1/%h", i, f_valid, f_y, exp_y[i]); else n_pass++;
    end
    tick();
    n_chk++; if (f_valid !== 1'b0) $display("FAIL fp_end_valid got %b want 0", f_valid); else n_pass++;
    n_chk++; if (f_pend !== 16'h0) $display("FAIL fp_end_pend got %h want 0000", f_pend); else n_pass++;
  endtask

  task automatic test_backpressure_ovf();
    do_reset();
    req = 16'h0003;
    tick();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (f_valid !== 1'b1 || f_y !== 4'h1)
        $display("FAIL bp_hold[%0d] got valid=%b y=%h want 1/1", i, f_valid, f_y); else n_pass++;
    end
    req = 16'h0002;
    tick();
    req = '0;
    n_chk++; if (f_ovf !== 1'b1)      $display("FAIL bp_ovf_pulse got %b want 1", f_ovf); else n_pass++;
    n_chk++; if (f_pend !== 16'h0003) $display("FAIL bp_ovf_pend got %h want 0003", f_pend); else n_pass++;
    n_chk++; if (f_y !== 4'h1)        $display("FAIL bp_ovf_y got %h want 1", f_y); else n_pass++;
    tick();
    n_chk++; if (f_ovf !== 1'b0) $display("FAIL bp_ovf_drop got %b want 0", f_ovf); else n_pass++;
    ready = 1'b1;
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_y !== 4'h0)
      $display("FAIL bp_next got valid=%b y=%h want 1/0", f_valid, f_y); else n_pass++;
    n_chk++; if (f_pend !== 16'h0001) $display("FAIL bp_next_pend got %h want 0001", f_pend); else n_pass++;
    tick();
    n_chk++; if (f_valid !== 1'b0 || f_pend !== 16'h0)
      $display("FAIL bp_drain got valid=%b pend=%h want 0/0000", f_valid, f_pend); else n_pass++;
    ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    ready = 1'b1;
    req   = 16'hFFFF;
    tick();
    n_chk++; if (r_valid !== 1'b0) $display("FAIL rr_capture_valid got %b want 0", r_valid); else n_pass++;
    for (int i = 0; i < 18; i++) begin
      tick();
      e = 4'(i);
      n_chk++; if (r_valid !== 1'b1 || r_y !== e)
        $display("FAIL rr_seq[%0d] got valid=%b y=%h want 1/%h", i, r_valid, r_y, e); else n_pass++;
    end
    req   = '0;
    ready = 1'b0;
  endtask

  task automatic test_enable_gating();
    do_reset();
    en  = 1'b0;
    req = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (f_pend !== 16'h0 || f_valid !== 1'b0 || f_ovf !== 1'b0)
        $display("FAIL gate_masked[%0d] got pend=%h valid=%b ovf=%b want 0000/0/0", i, f_pend, f_valid, f_ovf); else n_pass++;
    end
    en = 1'b1;
    tick();
    n_chk++; if (f_valid !== 1'b0 || f_pend !== 16'hFFFF)
      $display("FAIL gate_capture got valid=%b pend=%h want 0/ffff", f_valid, f_pend); else n_pass++;
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_y !== 4'hF)
      $display("FAIL gate_first got valid=%b y=%h want 1/f", f_valid, f_y); else n_pass++;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (f_valid !== 1'b1 || f_y !== 4'hF || f_pend !== 16'hFFFF)
        $display("FAIL full_hold[%0d] got valid=%b y=%h pend=%h want 1/f/ffff", i, f_valid, f_y, f_pend); else n_pass++;
    end
  endtask

  task automatic test_clear();
    do_reset();
    req = 16'h00F0;
    tick();
    req = '0;
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_y !== 4'h7)
      $display("FAIL clr_pre got valid=%b y=%h want 1/7", f_valid, f_y); else n_pass++;
    clr   = 1'b1;
    ready = 1'b1;
    req   = 16'h0001;
    tick();
    clr = 1'b0;
    req = '0;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL clr_valid got %b want 0", f_valid); else n_pass++;
    n_chk++; if (f_pend !== 16'h0) $display("FAIL clr_pend got %h want 0000", f_pend); else n_pass++;
    n_chk++; if (f_ovf !== 1'b0)   $display("FAIL clr_ovf got %b want 0", f_ovf); else n_pass++;
    n_chk++; if (f_y !== 4'h7)     $display("FAIL clr_y_keep got %h want 7", f_y); else n_pass++;
    tick();
    n_chk++; if (f_valid !== 1'b0 || f_pend !== 16'h0 || f_ovf !== 1'b0)
      $display("FAIL clr_idle got valid=%b pend=%h ovf=%b want 0/0000/0", f_valid, f_pend, f_ovf); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_hold();
    test_fixed_priority();
    test_backpressure_ovf();
    test_round_robin();
    test_enable_gating();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/req_encoder_16_to_4.md
Name: req_encoder_16_to_4

Overview:
- Sequential 16-to-4 request encoder. It is the counterpart of the team's 4-to-16 line decoder.
- Captures sticky event lines into a pending register and emits one 4-bit index at a time over a valid/ready handshake.
- Clears each served bit on handshake.
- Sits between event sources (IRQ lines, channel flags) and a consumer that accepts one encoded index per transfer.

Parameters:
- N, 16, number of request lines (fixed at 16 for this release; must be a power of 2).
- W, 4, code width, equal to log2(N).
- RR_EN, 0, arbitration mode: 0 = fixed priority, highest index wins; 1 = round-robin.

Ports:
- clk_i    input   1   clock, rising edge.
- rst_i    input   1   asynchronous reset, active-high.
- en_i     input   1   request capture enable. When 0, req_i is masked; pending bits are still served.
- req_i    input   16  request lines, sampled every cycle; bit k requests code k.
- clr_i    input   1   synchronous flush of all pending requests.
- ready_i  input   1   consumer accepts y_o when valid_o && ready_i.
- y_o      output  4   encoded index of the granted request (registered).
- valid_o  output  1   y_o holds a valid code (registered).
- pend_o   output  16  current pending register.
- ovf_o    output  1   one-cycle registered pulse: a request hit an already-pending, unserved bit.

Behaviour:
- Reset (async, rst_i=1): y_o=0, valid_o=0, pend_o=0, ovf_o=0, state=IDLE, RR pointer last=N-1. Asserting reset mid-transfer drops the transfer with no completion.
- Pending update each edge: pend <= (pend & ~served) | (req_i & {N{en_i}}).
  - served = onehot(y_o) when valid_o && ready_i, else 0.
  - If req_i re-asserts the bit being served in the same cycle, that bit stays set and ovf_o is not raised.
- ovf_o = |(req_i & {N{en_i}} & pend & ~served), registered, so the pulse appears one cycle later.
- Selection is combinational on the registered pend, excluding the served bit:
  - RR_EN=0: highest set index.
  - RR_EN=1: first set index searching last+1 up to N-1, then wrapping 0 up to last.
  - last updates to the granted code at every load.
- FSM with two states, IDLE and HOLD:
  - IDLE: if the candidate set is non-zero, load y_o with the selected index, set valid_o=1, go to HOLD. Otherwise stay, valid_o=0.
  - HOLD, valid_o && !ready_i: y_o and valid_o are held stable. No re-arbitration even if a higher-priority bit arrives.
  - HOLD, handshake: if (pend & ~served) != 0, load the next index on the same edge, keep valid_o=1, stay in HOLD. This gives back-to-back codes, one per cycle. Otherwise valid_o=0 and go to IDLE.
  - Requests arriving in the handshake cycle are visible from the following cycle only.
- Latency: req_i high at edge k sets pend at edge k; valid_o rises at edge k+1. Sustained throughput is 1 code/cycle with ready_i held high.
- clr_i has top priority:
  - Next edge: pend=0, valid_o=0, state=IDLE, ovf_o=0.
  - req_i in the same cycle is discarded, and a coincident handshake completes without effect.
  - y_o keeps its last value; last is unchanged.
- y_o is don't-care while valid_o=0, but holds its last value (no toggling).
- All 16 bits set with ready_i low: everything is held and no state is lost.

Decomposition:
- Shared package `enc_pkg`:
  - N/W constants.
  - State localparams ST_IDLE=1'b0, ST_HOLD=1'b1.
- Sub-module `prio_find`:
  - Purely combinational.
  - Parameter N.
  - Inputs: mask[N-1:0], start[W-1:0], rr_en.
  - Outputs: idx[W-1:0], found.
  - The top level instantiates it once.

Test Plan:
1. Reset mid-HOLD: pend=16'h0030, valid_o=1, assert rst_i -> immediately y_o=0, valid_o=0, pend_o=0, ovf_o=0. After release, no output until a new request arrives.
2. Fixed priority: RR_EN=0, en_i=1, one-cycle req_i=16'h8421, ready_i=1 -> valid_o rises 1 cycle after capture; y_o=F,A,5,0 on consecutive cycles; valid_o low after 4 cycles; pend_o ends at 0.
3. Backpressure and overflow: pend=16'h0003, ready_i=0 -> y_o=1 held stable for 5 cycles. Pulse req_i=16'h0002 -> ovf_o=1 for one cycle, pend unchanged. Then ready_i=1 -> y_o=0 follows.
4. Round-robin: RR_EN=1, req_i=16'hFFFF held, ready_i=1 -> y_o=0,1,...,F,0,1 with valid_o continuously high.
5. Enable gating: en_i=0, req_i=16'hFFFF for 4 cycles -> pend_o=0, valid_o=0, ovf_o=0. Then en_i=1 -> valid_o rises 2 edges later with y_o=F (fixed mode).
6. Clear: HOLD with pend=16'h00F0, apply clr_i together with ready_i=1 and req_i=16'h0001 -> next cycle valid_o=0, pend_o=0, state IDLE, no ovf_o.
